// File: rtl/axi4_lite_lsu_bridge_pkg.sv
// Shared types and constants for the RV32 load/store bridge.
// Includes a misalignment helper, used only when AXI_LSU_MISALIGN_TRAP_EN is defined.
package axi_lsu_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      ARM   = 3'd2,
      WAIT  = 3'd3,
      RESP  = 3'd4
   } lsu_state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Unsupported funct3 codes behave as word accesses, so they need full word alignment.
   function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
      logic mis;
      case (funct3)
         F3_B, F3_BU: mis = 1'b0;
         F3_H, F3_HU: mis = addr_lo[0];
         default:     mis = (addr_lo != 2'b00);
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/axi4_lite_lsu_bridge_if.sv
// Start/busy bus between the LSU bridge (master) and the peripheral top (slave).
interface axi4_lite_lsu_bridge_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   // Handshake: the master raises *_start for exactly one cycle with addr/data/strobe
   // already stable; the slave raises *_busy starting the following cycle and holds it
   // until the access is done; read_data is valid once read_busy has fallen.
   logic                      write_start;
   logic [ADDR_WIDTH-1:0]     write_addr;
   logic [DATA_WIDTH-1:0]     write_data;
   logic [DATA_WIDTH/8-1:0]   write_strobe;
   logic                      write_busy;
   logic                      read_start;
   logic [ADDR_WIDTH-1:0]     read_addr;
   logic [DATA_WIDTH-1:0]     read_data;
   logic                      read_busy;

   modport master (
      output write_start, write_addr, write_data, write_strobe,
      output read_start, read_addr,
      input  write_busy, read_busy, read_data
   );

   modport slave (
      input  write_start, write_addr, write_data, write_strobe,
      input  read_start, read_addr,
      output write_busy, read_busy, read_data
   );
endinterface

// File: rtl/axi4_lite_lsu_bridge_data_align.sv
// Combinational byte-lane logic: store strobes/replication and load lane select/extension.
module lsu_data_align
   import axi_lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] store_data,
   input  logic [31:0] load_word,
   output logic [3:0]  strobe,
   output logic [31:0] store_wdata,
   output logic [31:0] load_ext
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   always_comb begin
      lane_b = load_word[7:0];
      case (addr_lo)
         2'd1:    lane_b = load_word[15:8];
         2'd2:    lane_b = load_word[23:16];
         2'd3:    lane_b = load_word[31:24];
         default: lane_b = load_word[7:0];
      endcase
      // a[0] is ignored for halves, so an odd half address reads the half chosen by a[1].
      lane_h = addr_lo[1] ? load_word[31:16] : load_word[15:0];
   end

   always_comb begin
      strobe      = 4'b1111;
      store_wdata = store_data;
      load_ext    = load_word;
      case (funct3)
         F3_B, F3_BU: begin
            strobe      = 4'b0001 << addr_lo;
            store_wdata = {4{store_data[7:0]}};
         end
         F3_H, F3_HU: begin
            strobe      = 4'b0011 << {addr_lo[1], 1'b0};
            store_wdata = {2{store_data[15:0]}};
         end
         default: ;
      endcase
      case (funct3)
         F3_B:    load_ext = {{24{lane_b[7]}}, lane_b};
         F3_BU:   load_ext = {24'd0, lane_b};
         F3_H:    load_ext = {{16{lane_h[15]}}, lane_h};
         F3_HU:   load_ext = {16'd0, lane_h};
         default: load_ext = load_word;
      endcase
   end

endmodule

// File: rtl/axi4_lite_lsu_bridge.sv
// Bridges RV32 memory-stage loads/stores onto the single-beat start/busy peripheral bus.
// Optional feature macro: AXI_LSU_MISALIGN_TRAP_EN (trap misaligned H/W accesses).
module axi4_lite_lsu_bridge
   import axi_lsu_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mem_read,
   input  logic                  mem_write,
   input  logic [2:0]            funct3,
   input  logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] store_data,
   output logic                  stall,
   output logic [DATA_WIDTH-1:0] load_data,
   output logic                  load_valid,
   output logic                  misaligned,
   output lsu_state_t            state_dbg,
   axi4_lite_lsu_bridge_if.master bus
);

   lsu_state_t            state, state_nxt;
   logic                  req_write;
   logic [2:0]            req_f3;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_data;
   logic                  req_mis;
   logic [DATA_WIDTH-1:0] load_q;

   logic                  req_any;
   logic                  mis_now;
   logic                  busy_sel;
   logic [ADDR_WIDTH-1:0] word_addr;
   logic [3:0]            align_strobe;
   logic [31:0]           align_wdata;
   logic [31:0]           align_load;

   assign req_any   = mem_read | mem_write;
   assign busy_sel  = req_write ? bus.write_busy : bus.read_busy;
   assign word_addr = {req_addr[ADDR_WIDTH-1:2], 2'b00};
   assign state_dbg = state;

`ifdef AXI_LSU_MISALIGN_TRAP_EN
   assign mis_now = is_misaligned(funct3, mem_addr[1:0]);
`else
   assign mis_now = 1'b0;
`endif

   lsu_data_align u_align (
      .funct3      (req_f3),
      .addr_lo     (req_addr[1:0]),
      .store_data  (req_data),
      .load_word   (bus.read_data),
      .strobe      (align_strobe),
      .store_wdata (align_wdata),
      .load_ext    (align_load)
   );

   // Request fields are frozen from acceptance until the next acceptance, so the bus
   // address/data/strobe stay stable through ISSUE..RESP.
   assign bus.write_addr   = req_write ? word_addr    : '0;
   assign bus.write_data   = req_write ? align_wdata  : '0;
   assign bus.write_strobe = req_write ? align_strobe : 4'b0000;
   assign bus.read_addr    = req_write ? '0 : word_addr;
   assign load_data        = load_valid ? load_q : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt       = state;
      stall           = 1'b0;
      bus.write_start = 1'b0;
      bus.read_start  = 1'b0;
      load_valid      = 1'b0;
      misaligned      = 1'b0;
      case (state)
         IDLE: begin
            if (req_any) begin
               stall     = ~rst;
               state_nxt = mis_now ? RESP : ISSUE;
            end
         end
         ISSUE: begin
            stall           = ~rst;
            bus.write_start = req_write;
            bus.read_start  = ~req_write;
            state_nxt       = ARM;
         end
         ARM: begin
            stall     = ~rst;
            state_nxt = WAIT;
         end
         WAIT: begin
            stall = ~rst;
            if (!busy_sel) state_nxt = RESP;
         end
         RESP: begin
            load_valid = ~req_write & ~req_mis;
            misaligned = req_mis;
            state_nxt  = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_write <= 1'b0;
         req_f3    <= 3'b000;
         req_addr  <= '0;
         req_data  <= '0;
         req_mis   <= 1'b0;
         load_q    <= '0;
      end else begin
         // A store wins over a simultaneous load; the load is simply not taken.
         if (state == IDLE && req_any) begin
            req_write <= mem_write;
            req_f3    <= funct3;
            req_addr  <= mem_addr;
            req_data  <= store_data;
            req_mis   <= mis_now;
         end
         if (state == WAIT && !req_write && !bus.read_busy) begin
            load_q <= align_load;
         end
      end
   end

endmodule
